// File: rtl/counter_chk_pkg.sv
// Shared types and defaults for the counter stream checker.
package counter_chk_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ERR_W = 16;

    localparam logic [DEF_ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } chk_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/counter_checker.sv
// Sink-side checker for a free-running counter stream: tracks the next
// expected value and flags mismatches, counter resets and wraps.
module counter_checker
    import counter_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ERR_W = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_value,
    input  logic             in_valid,
    input  logic             in_enable,
    output logic             locked,
    output logic             err,
    output logic             zero_seen,
    output logic             wrap,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] exp_value
);

    chk_state_t       state, state_nx;
    logic [WIDTH-1:0] exp_nx;
    logic [WIDTH-1:0] follow;
    logic             prev_ones, prev_ones_nx;
    logic             err_nx, zero_nx, wrap_nx;

    // Counter updates on the edge after enable is seen, so this sample's
    // enable decides the next expectation.
    assign follow = in_value + WIDTH'(in_enable);

    always_comb begin
        state_nx     = state;
        exp_nx       = exp_value;
        prev_ones_nx = prev_ones;
        err_nx       = 1'b0;
        zero_nx      = 1'b0;
        wrap_nx      = 1'b0;
        case (state)
            UNLOCKED: begin
                if (in_valid) begin
                    state_nx     = LOCKED;
                    exp_nx       = follow;
                    prev_ones_nx = &in_value;
                end
            end
            LOCKED: begin
                if (!in_valid) begin
                    state_nx = UNLOCKED;
                end else begin
                    exp_nx       = follow;
                    prev_ones_nx = &in_value;
                    if (in_value == exp_value) begin
                        wrap_nx = (exp_value == '0) && prev_ones;
                    end else if (in_value == '0) begin
                        zero_nx = 1'b1;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            default: state_nx = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= UNLOCKED;
            exp_value <= '0;
            prev_ones <= 1'b0;
            err       <= 1'b0;
            zero_seen <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_nx;
            exp_value <= exp_nx;
            prev_ones <= prev_ones_nx;
            err       <= err_nx;
            zero_seen <= zero_nx;
            wrap      <= wrap_nx;
        end
    end

    assign locked = (state == LOCKED);

    sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (err_nx),
        .count(err_count)
    );

endmodule

// File: tb/tb_counter_checker.sv
// Randomized and directed bench for counter_checker against a reference model.
module tb_counter_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_value = '0;
    logic        in_valid = 1'b0;
    logic        in_enable = 1'b0;

    logic        locked, err, zero_seen, wrap;
    logic [15:0] err_count;
    logic [7:0]  exp_value;

    logic        s_locked, s_err, s_zero, s_wrap;
    logic [1:0]  s_count;
    logic [7:0]  s_exp;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit         e_locked, e_err, e_zero, e_wrap;
    logic [7:0] e_exp;
    logic [7:0] prev;
    int         errs;

    always #5 clk = ~clk;

    counter_checker dut (
        .clk      (clk),
        .reset    (reset),
        .in_value (in_value),
        .in_valid (in_valid),
        .in_enable(in_enable),
        .locked   (locked),
        .err      (err),
        .zero_seen(zero_seen),
        .wrap     (wrap),
        .err_count(err_count),
        .exp_value(exp_value)
    );

    counter_checker #(.WIDTH(8), .ERR_W(2)) dut_s (
        .clk      (clk),
        .reset    (reset),
        .in_value (in_value),
        .in_valid (in_valid),
        .in_enable(in_enable),
        .locked   (s_locked),
        .err      (s_err),
        .zero_seen(s_zero),
        .wrap     (s_wrap),
        .err_count(s_count),
        .exp_value(s_exp)
    );

    function automatic logic [15:0] cnt16();
        return 16'(errs > 65535 ? 65535 : errs);
    endfunction

    function automatic logic [1:0] cnt2();
        return 2'(errs > 3 ? 3 : errs);
    endfunction

    task automatic model_clear();
        e_locked = 0; e_err = 0; e_zero = 0; e_wrap = 0;
        e_exp = '0; prev = '0; errs = 0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset = 1'b0;
        #3;
        model_clear();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // drive one sample, then advance the model by the rules of the stream
    task automatic step(input logic [7:0] v, input bit vd, input bit en);
        in_value = v; in_valid = vd; in_enable = en;
        @(posedge clk);
        #1;
        e_err = 0; e_zero = 0; e_wrap = 0;
        if (!vd) begin
            e_locked = 0;
        end else begin
            if (e_locked) begin
                if (v == e_exp) e_wrap = (e_exp == 0) && (prev == 8'hFF);
                else if (v == 0) e_zero = 1;
                else begin e_err = 1; errs++; end
            end
            e_locked = 1;
            e_exp = 8'((int'(v) + int'(en)) % 256);
            prev = v;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_clear();
        n_tests++;
        if ({locked, err, zero_seen, wrap} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {locked, err, zero_seen, wrap});
        end
        n_tests++;
        if (err_count !== 16'h0 || exp_value !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_regs: got cnt=%h exp=%h expected 0/0", err_count, exp_value);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_count_run();
        do_reset();
        for (int i = 0; i <= 32; i++) begin
            step(8'(16 + i), 1, 1);
            n_tests++;
            if (locked !== 1'b1 || err !== 1'b0 || exp_value !== e_exp) begin
                n_fail++;
                $display("FAIL count_run[%0d]: got lk=%b err=%b exp=%h expected 1/0/%h",
                         i, locked, err, exp_value, e_exp);
            end
        end
        n_tests++;
        if (exp_value !== 8'h31) begin
            n_fail++;
            $display("FAIL count_run_final: got %h expected 31", exp_value);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] seq [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        int nw = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(seq[i], 1, 1);
            nw += int'(wrap);
            n_tests++;
            if (wrap !== e_wrap || err !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got wrap=%b err=%b expected %b/0", i, wrap, err, e_wrap);
            end
        end
        n_tests++;
        if (nw != 1 || err_count !== 16'h0) begin
            n_fail++;
            $display("FAIL wrap_total: got pulses=%0d cnt=%h expected 1/0", nw, err_count);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] seq [4] = '{8'h40, 8'h41, 8'h47, 8'h48};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(seq[i], 1, 1);
            n_tests++;
            if (err !== e_err || err !== (i == 2)) begin
                n_fail++;
                $display("FAIL glitch[%0d]: got err=%b expected %b", i, err, e_err);
            end
        end
        n_tests++;
        if (err_count !== 16'd1) begin
            n_fail++;
            $display("FAIL glitch_count: got %0d expected 1", err_count);
        end
    endtask

    task automatic test_counter_reset();
        logic [7:0] seq [4] = '{8'h55, 8'h56, 8'h00, 8'h01};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(seq[i], 1, 1);
            n_tests++;
            if (zero_seen !== (i == 2) || err !== 1'b0 || zero_seen !== e_zero) begin
                n_fail++;
                $display("FAIL cnt_reset[%0d]: got zero=%b err=%b expected %b/0",
                         i, zero_seen, err, e_zero);
            end
        end
    endtask

    task automatic test_hold();
        logic [7:0] seq [5] = '{8'h20, 8'h21, 8'h21, 8'h21, 8'h22};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(seq[i], 1, i == 0);
            n_tests++;
            if (err !== (i == 4) || err !== e_err) begin
                n_fail++;
                $display("FAIL hold[%0d]: got err=%b expected %b", i, err, e_err);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 0, 1);
            n_tests++;
            if (locked !== 1'b0 || {err, zero_seen, wrap} !== 3'b0) begin
                n_fail++;
                $display("FAIL unlock[%0d]: got lk=%b flags=%b expected 0/000",
                         i, locked, {err, zero_seen, wrap});
            end
        end
        step(8'h90, 1, 1);
        n_tests++;
        if (locked !== 1'b1 || {err, zero_seen, wrap} !== 3'b0 || exp_value !== 8'h91) begin
            n_fail++;
            $display("FAIL relock: got lk=%b flags=%b exp=%h expected 1/000/91",
                     locked, {err, zero_seen, wrap}, exp_value);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        step(8'h10, 1, 1);
        for (int i = 0; i < 5; i++) step(8'(8'h50 + 16 * i), 1, 1);
        n_tests++;
        if (s_count !== 2'd3 || s_count !== cnt2()) begin
            n_fail++;
            $display("FAIL saturate_w2: got %0d expected 3", s_count);
        end
        n_tests++;
        if (err_count !== 16'd5) begin
            n_fail++;
            $display("FAIL saturate_w16: got %0d expected 5", err_count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(8'h30, 1, 1);
        step(8'h31, 1, 1);
        step(8'h77, 1, 1);
        step(8'h78, 1, 1);
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({locked, err, zero_seen, wrap} !== 4'b0 || err_count !== 16'h0 ||
            exp_value !== 8'h0 || s_count !== 2'h0) begin
            n_fail++;
            $display("FAIL async_reset: got flags=%b cnt=%h exp=%h expected 0000/0/0",
                     {locked, err, zero_seen, wrap}, err_count, exp_value);
        end
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        step(8'hA5, 1, 0);
        n_tests++;
        if (locked !== 1'b1 || {err, zero_seen, wrap} !== 3'b0 || exp_value !== 8'hA5) begin
            n_fail++;
            $display("FAIL first_after_reset: got lk=%b flags=%b exp=%h expected 1/000/a5",
                     locked, {err, zero_seen, wrap}, exp_value);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        logic [7:0] v;
        int r;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70 && e_locked) v = e_exp;
            else if (r < 80) v = 8'h00;
            else if (r < 85) v = 8'hFF;
            else v = 8'($urandom);
            step(v, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0);
            n_tests++;
            if (locked !== e_locked || err !== e_err || zero_seen !== e_zero ||
                wrap !== e_wrap || exp_value !== e_exp || err_count !== cnt16() ||
                s_count !== cnt2()) begin
                n_fail++;
                bad++;
                if (bad < 10)
                    $display("FAIL random[%0d]: got lk=%b e=%b z=%b w=%b x=%h c=%0d s=%0d expected %b %b %b %b %h %0d %0d",
                             i, locked, err, zero_seen, wrap, exp_value, err_count, s_count,
                             e_locked, e_err, e_zero, e_wrap, e_exp, cnt16(), cnt2());
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_run();
        test_wrap();
        test_glitch();
        test_counter_reset();
        test_hold();
        test_saturate();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
